// File: rtl/rv_multicycle_ctrl_v2.sv
// rv_multicycle_ctrl_v2: multicycle RV32I control FSM with memory handshakes, optional MUL/DIV wait, trap/halt and retire counter
module rv_multicycle_ctrl_v2 #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit ENABLE_MULDIV = 1'b0,
   parameter bit TRAP_HALT     = 1'b0,
   parameter int CNT_W         = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             mem_ready,
   input  logic             md_done,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrc1,
   output logic             ALUSrc2,
   output logic             Branch,
   output logic             Jump,
   output logic             JALorJALR,
   output logic [6:0]       ALUOp,
   output logic [3:0]       BE,
   output logic [2:0]       Concat_control,
   output logic             md_start,
   output logic             trap,
   output logic             halted,
   output logic [CNT_W-1:0] retired,
   output logic [4:0]       state
);
   typedef enum logic [4:0] {
      FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, I_EX, ALU_WB,
      MD_EX, BR_EX, JAL_EX, JALR_EX, JMP_WB, U_EX, U_WB, TRAP, HALT
   } state_t;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;
   state_t     cur, nxt, dec;
   logic       rdy, md_busy, retire;
   logic [3:0] be_sz;
   assign rdy    = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign retire = (cur inside {MEM_WB, ALU_WB, BR_EX, JMP_WB, U_WB}) || (cur == MEM_WR && rdy);
   always_ff @(posedge CLK) begin
      if (RSTn) begin
         cur     <= FETCH;
         md_busy <= 1'b0;
         retired <= '0;
      end else begin
         cur     <= nxt;
         md_busy <= cur == MD_EX && nxt == MD_EX;
         retired <= retired + CNT_W'(retire);
      end
   end
   always_comb begin
      dec = TRAP;
      if (opcode == OP_LOAD && funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec = MEM_ADDR;
      else if (opcode == OP_STORE && funct3 inside {3'b000, 3'b001, 3'b010}) dec = MEM_ADDR;
      else if (opcode == OP_R) dec = funct7 == 7'b0000001 ? (ENABLE_MULDIV ? MD_EX : TRAP) : R_EX;
      else if (opcode == OP_BR) dec = BR_EX;
      else if (opcode == OP_JAL) dec = JAL_EX;
      else if (opcode == OP_JALR) dec = JALR_EX;
      else if (opcode == OP_I) dec = I_EX;
      else if (opcode == OP_LUI || opcode == OP_AUIPC) dec = U_EX;
      else if (opcode == OP_SYS) dec = HALT;
   end
   always_comb begin
      nxt = cur;
      case (cur)
         FETCH:                               nxt = rdy ? DECODE : FETCH;
         DECODE:                              nxt = dec;
         MEM_ADDR:                            nxt = opcode == OP_STORE ? MEM_WR : MEM_RD;
         MEM_RD:                              nxt = rdy ? MEM_WB : MEM_RD;
         MEM_WR:                              nxt = rdy ? FETCH : MEM_WR;
         R_EX, I_EX:                          nxt = ALU_WB;
         MD_EX:                               nxt = md_done ? ALU_WB : MD_EX;
         MEM_WB, ALU_WB, BR_EX, JMP_WB, U_WB: nxt = FETCH;
         JAL_EX, JALR_EX:                     nxt = JMP_WB;
         U_EX:                                nxt = U_WB;
         TRAP:                                nxt = TRAP_HALT ? HALT : FETCH;
         default:                             nxt = HALT;
      endcase
   end
   // access size comes from funct3[1:0]; the unsigned-load bit does not change it
   assign be_sz = funct3[1:0] == 2'b00 ? 4'b0001 : funct3[1:0] == 2'b01 ? 4'b0011 :
                  funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
   assign state     = cur;
   assign ALUOp     = opcode;
   assign PCWrite   = cur == FETCH && rdy;
   assign IRWrite   = PCWrite;
   assign MemRead   = cur == FETCH || cur == MEM_RD;
   assign MemWrite  = cur == MEM_WR;
   assign MemtoReg  = cur == MEM_WB;
   assign RegWrite  = cur inside {MEM_WB, ALU_WB, JMP_WB, U_WB};
   assign RegDst    = RegWrite;
   assign ALUSrc1   = cur inside {JAL_EX, U_EX};
   assign ALUSrc2   = cur inside {MEM_ADDR, I_EX, JAL_EX, JALR_EX, U_EX};
   assign Branch    = cur == BR_EX;
   assign Jump      = cur inside {JAL_EX, JALR_EX, JMP_WB};
   assign JALorJALR = cur == JALR_EX;
   assign BE        = cur inside {MEM_RD, MEM_WR} ? be_sz : 4'b0000;
   assign Concat_control = cur == MEM_ADDR ? (opcode == OP_STORE ? 3'b101 : 3'b011) :
                           cur == I_EX     ? (funct3[1:0] == 2'b01 ? 3'b110 : 3'b011) :
                           cur == BR_EX    ? 3'b100 :
                           cur == JAL_EX   ? 3'b010 :
                           cur == JALR_EX  ? 3'b011 :
                           cur == U_EX     ? 3'b001 : 3'b000;
   assign md_start  = cur == MD_EX && !md_busy;
   assign trap      = cur == TRAP;
   assign halted    = cur == HALT;
endmodule

// File: tb/tb_rv_multicycle_ctrl_v2.sv
// tb_rv_multicycle_ctrl_v2: randomized instruction-level checks of the control FSM against a per-instruction phase model
module tb_rv_multicycle_ctrl_v2;
   logic       CLK = 1'b0, RSTn = 1'b1;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic       mem_ready = 1'b0, md_done = 1'b0;
   wire  [2:0] pcw, irw, mrd, mwr, m2r, rwr, rdst, as1, as2, br, jmp, jj, mds, trp, hlt;
   wire  [3:0] be [3];
   wire  [2:0] cc [3];
   wire  [6:0] aluop [3];
   wire  [4:0] st [3];
   wire  [31:0] ret0, ret2;
   wire  [3:0]  ret1;
   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
      OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_I = 7'b0010011,
      OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_SYS = 7'b1110011;
   localparam logic [21:0] PCW = 22'd1 << 21, IRW = 22'd1 << 20, MR = 22'd1 << 19, MW = 22'd1 << 18,
      M2R = 22'd1 << 17, RW = 22'd1 << 16, RD = 22'd1 << 15, AS1 = 22'd1 << 14, AS2 = 22'd1 << 13,
      BR = 22'd1 << 12, J = 22'd1 << 11, JJ = 22'd1 << 10, MDS = 22'd1 << 2, TRP = 22'd1 << 1, HLT = 22'd1;
   typedef struct {logic [21:0] exp; int mr; int md; bit ret;} phase_t;
   phase_t q[$];
   int     errors = 0, checks = 0, cnt0 = 0, cnt1 = 0;

   // d0: defaults; d1: MUL/DIV on, trap halts, 4-bit counter; d2: no memory handshake
   rv_multicycle_ctrl_v2 d0 (.CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .md_done(md_done), .PCWrite(pcw[0]), .IRWrite(irw[0]), .MemRead(mrd[0]),
      .MemWrite(mwr[0]), .MemtoReg(m2r[0]), .RegWrite(rwr[0]), .RegDst(rdst[0]), .ALUSrc1(as1[0]),
      .ALUSrc2(as2[0]), .Branch(br[0]), .Jump(jmp[0]), .JALorJALR(jj[0]), .ALUOp(aluop[0]), .BE(be[0]),
      .Concat_control(cc[0]), .md_start(mds[0]), .trap(trp[0]), .halted(hlt[0]), .retired(ret0), .state(st[0]));
   rv_multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b1), .ENABLE_MULDIV(1'b1), .TRAP_HALT(1'b1), .CNT_W(4)) d1 (
      .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .md_done(md_done), .PCWrite(pcw[1]), .IRWrite(irw[1]), .MemRead(mrd[1]),
      .MemWrite(mwr[1]), .MemtoReg(m2r[1]), .RegWrite(rwr[1]), .RegDst(rdst[1]), .ALUSrc1(as1[1]),
      .ALUSrc2(as2[1]), .Branch(br[1]), .Jump(jmp[1]), .JALorJALR(jj[1]), .ALUOp(aluop[1]), .BE(be[1]),
      .Concat_control(cc[1]), .md_start(mds[1]), .trap(trp[1]), .halted(hlt[1]), .retired(ret1), .state(st[1]));
   rv_multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b0)) d2 (.CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .mem_ready(mem_ready), .md_done(md_done), .PCWrite(pcw[2]), .IRWrite(irw[2]),
      .MemRead(mrd[2]), .MemWrite(mwr[2]), .MemtoReg(m2r[2]), .RegWrite(rwr[2]), .RegDst(rdst[2]),
      .ALUSrc1(as1[2]), .ALUSrc2(as2[2]), .Branch(br[2]), .Jump(jmp[2]), .JALorJALR(jj[2]), .ALUOp(aluop[2]),
      .BE(be[2]), .Concat_control(cc[2]), .md_start(mds[2]), .trap(trp[2]), .halted(hlt[2]), .retired(ret2),
      .state(st[2]));

   always #5 CLK = ~CLK;

   function automatic logic [21:0] ob(int i);
      return {pcw[i], irw[i], mrd[i], mwr[i], m2r[i], rwr[i], rdst[i], as1[i], as2[i], br[i], jmp[i], jj[i],
              be[i], cc[i], mds[i], trp[i], hlt[i]};
   endfunction
   function automatic logic [31:0] rt(int i);
      return i == 0 ? ret0 : i == 1 ? 32'(ret1) : ret2;
   endfunction
   function automatic logic [21:0] be_f(logic [3:0] b);
      return {12'b0, b, 6'b0};
   endfunction
   function automatic logic [21:0] cc_f(logic [2:0] c);
      return {16'b0, c, 3'b0};
   endfunction

   task automatic push(logic [21:0] e, int mr = 2, int md = 2, bit r = 1'b0);
      q.push_back('{e, mr, md, r});
   endtask

   // expected cycle-by-cycle outputs of one instruction; fw/mw are memory wait cycles, mdl the MUL/DIV latency
   task automatic build(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, bit md_en, bit th, int fw, int mw, int mdl);
      bit         tr = 1'b0;
      logic [3:0] b;
      case (f3)
         3'd0, 3'd4: b = 4'b0001;
         3'd1, 3'd5: b = 4'b0011;
         default:    b = 4'b1111;
      endcase
      repeat (fw) push(MR, 0);
      push(MR | PCW | IRW, 1);
      push(22'd0);
      if (op == OP_LOAD && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
         push(AS2 | cc_f(3'b011));
         repeat (mw) push(MR | be_f(b), 0);
         push(MR | be_f(b), 1);
         push(M2R | RW | RD, 2, 2, 1'b1);
      end else if (op == OP_STORE && f3 inside {3'd0, 3'd1, 3'd2}) begin
         push(AS2 | cc_f(3'b101));
         repeat (mw) push(MW | be_f(b), 0);
         push(MW | be_f(b), 1, 2, 1'b1);
      end else if (op == OP_R && f7 == 7'b0000001) begin
         if (md_en) begin
            for (int k = 1; k <= mdl; k++) push(k == 1 ? MDS : 22'd0, 2, int'(k == mdl));
            push(RW | RD, 2, 2, 1'b1);
         end else tr = 1'b1;
      end else if (op == OP_R) begin
         push(22'd0);
         push(RW | RD, 2, 2, 1'b1);
      end else if (op == OP_BR) push(BR | cc_f(3'b100), 2, 2, 1'b1);
      else if (op == OP_JAL || op == OP_JALR) begin
         push(op == OP_JAL ? (AS1 | AS2 | J | cc_f(3'b010)) : (AS2 | J | JJ | cc_f(3'b011)));
         push(J | RW | RD, 2, 2, 1'b1);
      end else if (op == OP_I) begin
         push(AS2 | cc_f((f3 == 3'd1 || f3 == 3'd5) ? 3'b110 : 3'b011));
         push(RW | RD, 2, 2, 1'b1);
      end else if (op == OP_LUI || op == OP_AUIPC) begin
         push(AS1 | AS2 | cc_f(3'b001));
         push(RW | RD, 2, 2, 1'b1);
      end else if (op == OP_SYS) repeat (4) push(HLT);
      else tr = 1'b1;
      if (tr) begin
         push(TRP);
         if (th) repeat (4) push(HLT);
      end
   endtask

   // plays the queued phases from a falling edge, checking d0 and/or d1; stops early after lim phases
   task automatic run(bit c0, bit c1, logic [6:0] op, logic [2:0] f3, logic [6:0] f7, int lim = 1000);
      opcode = op; funct3 = f3; funct7 = f7;
      for (int k = 0; k < q.size() && k < lim; k++) begin
         mem_ready = q[k].mr == 2 ? 1'($urandom) : 1'(q[k].mr);
         md_done   = q[k].md == 2 ? 1'($urandom) : 1'(q[k].md);
         #1;
         if (c0) begin
            checks++;
            if (ob(0) !== q[k].exp || aluop[0] !== op || ret0 !== 32'(cnt0)) begin
               errors++;
               $display("FAIL d0 op=%b f3=%0d cyc=%0d: got outs=%h aluop=%b retired=%0d, need outs=%h aluop=%b retired=%0d",
                        op, f3, k, ob(0), aluop[0], ret0, q[k].exp, op, cnt0);
            end
         end
         if (c1) begin
            checks++;
            if (ob(1) !== q[k].exp || aluop[1] !== op || ret1 !== 4'(cnt1)) begin
               errors++;
               $display("FAIL d1 op=%b f3=%0d cyc=%0d: got outs=%h aluop=%b retired=%0d, need outs=%h aluop=%b retired=%0d",
                        op, f3, k, ob(1), aluop[1], ret1, q[k].exp, op, cnt1 % 16);
            end
         end
         if (q[k].ret) begin cnt0++; cnt1++; end
         @(negedge CLK);
      end
      q.delete();
   endtask

   task automatic do_reset();
      logic [21:0] e;
      RSTn = 1'b1; mem_ready = 1'($urandom); md_done = 1'b1;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         e = MR | ((i == 2 || mem_ready) ? (PCW | IRW) : 22'd0);
         checks++;
         if (ob(i) !== e || rt(i) !== 32'd0) begin
            errors++;
            $display("FAIL reset d%0d: got outs=%h retired=%0d, need outs=%h retired=0", i, ob(i), rt(i), e);
         end
      end
      RSTn = 1'b0; cnt0 = 0; cnt1 = 0;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_add();
      build(OP_R, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b1, OP_R, 3'd0, 7'd0);
      checks++;
      if (ret0 !== 32'd1 || ret1 !== 4'd1) begin
         errors++;
         $display("FAIL add_retired: got %0d/%0d, need 1/1", ret0, ret1);
      end
   endtask

   task automatic test_load();
      build(OP_LOAD, 3'd2, 7'd0, 1'b0, 1'b0, 0, 3, 1);
      run(1'b1, 1'b1, OP_LOAD, 3'd2, 7'd0);
      build(OP_LOAD, 3'd4, 7'd0, 1'b0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), 1);
      run(1'b1, 1'b1, OP_LOAD, 3'd4, 7'd0);
   endtask

   task automatic test_store();
      build(OP_STORE, 3'd1, 7'd0, 1'b0, 1'b0, 1, 2, 1);
      run(1'b1, 1'b1, OP_STORE, 3'd1, 7'd0);
   endtask

   task automatic test_muldiv();
      do_reset();
      build(OP_R, 3'd0, 7'b0000001, 1'b1, 1'b1, 0, 0, 4);
      run(1'b0, 1'b1, OP_R, 3'd0, 7'b0000001);
      build(OP_R, 3'd4, 7'b0000001, 1'b1, 1'b1, 0, 0, 1);
      run(1'b0, 1'b1, OP_R, 3'd4, 7'b0000001);
      do_reset();
      build(OP_R, 3'd0, 7'b0000001, 1'b0, 1'b0, 0, 0, 4);
      run(1'b1, 1'b0, OP_R, 3'd0, 7'b0000001);
      build(OP_R, 3'd0, 7'b0100000, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b0, OP_R, 3'd0, 7'b0100000);
      do_reset();
   endtask

   task automatic test_trap_halt();
      build(OP_BR, 3'd1, 7'd0, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b1, OP_BR, 3'd1, 7'd0);
      build(7'b1111111, 3'd0, 7'd0, 1'b1, 1'b1, 0, 0, 1);
      run(1'b0, 1'b1, 7'b1111111, 3'd0, 7'd0);
      do_reset();
      build(OP_SYS, 3'd0, 7'd0, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b1, OP_SYS, 3'd0, 7'd0);
      do_reset();
      build(OP_LOAD, 3'd3, 7'd0, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b0, OP_LOAD, 3'd3, 7'd0);
      build(OP_I, 3'd5, 7'd0, 1'b0, 1'b0, 0, 0, 1);
      run(1'b1, 1'b0, OP_I, 3'd5, 7'd0);
      do_reset();
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (16) begin
         build(OP_BR, 3'($urandom), 7'd0, 1'b0, 1'b0, $urandom_range(0, 1), 0, 1);
         run(1'b1, 1'b1, OP_BR, q.size() > 0 ? funct3 : 3'd0, 7'd0);
      end
      checks++;
      if (ret1 !== 4'd0 || ret0 !== 32'd16) begin
         errors++;
         $display("FAIL wrap: got d1=%0d d0=%0d, need d1=0 d0=16", ret1, ret0);
      end
   endtask

   task automatic test_random();
      logic [6:0] op, f7;
      logic [2:0] f3;
      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom);
         f7 = 7'($urandom) & 7'h7e;
         case ($urandom_range(0, 8))
            0: begin op = OP_LOAD; f3 = 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0); if (f3 == 3'd6) f3 = 3'd2; end
            1: begin op = OP_STORE; f3 = 3'($urandom_range(0, 2)); end
            2: op = OP_R;
            3: op = OP_BR;
            4: op = OP_JAL;
            5: op = OP_JALR;
            6: op = OP_I;
            7: op = OP_LUI;
            default: op = OP_AUIPC;
         endcase
         build(op, f3, f7, 1'b0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), 1);
         run(1'b1, 1'b1, op, f3, f7);
      end
   endtask

   task automatic test_reset_mid();
      build(OP_LOAD, 3'd1, 7'd0, 1'b0, 1'b0, 0, 5, 1);
      run(1'b1, 1'b1, OP_LOAD, 3'd1, 7'd0, 5);
      do_reset();
      build(OP_R, 3'd0, 7'b0000001, 1'b1, 1'b1, 0, 0, 6);
      run(1'b0, 1'b1, OP_R, 3'd0, 7'b0000001, 4);
      do_reset();
      build(OP_R, 3'd0, 7'b0000001, 1'b1, 1'b1, 0, 0, 2);
      run(1'b0, 1'b1, OP_R, 3'd0, 7'b0000001);
      do_reset();
   endtask

   task automatic test_no_handshake();
      opcode = OP_R; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b0; md_done = 1'b0;
      #1;
      checks++;
      if (pcw[2] !== 1'b1 || pcw[0] !== 1'b0) begin
         errors++;
         $display("FAIL nohs_fetch: got PCWrite d2=%b d0=%b, need 1/0", pcw[2], pcw[0]);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (ret2 !== 32'd1 || ob(0) !== MR) begin
         errors++;
         $display("FAIL nohs_retire: got d2 retired=%0d d0 outs=%h, need 1 and %h", ret2, ob(0), MR);
      end
      do_reset();
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_add();
      test_load();
      test_store();
      test_muldiv();
      test_trap_halt();
      test_wrap();
      test_random();
      test_reset_mid();
      test_no_handshake();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
